// File: rtl/gpio_aux_ctrl_if.sv
// rtl/gpio_aux_ctrl_if.sv - register-bank side signal bundle for gpio_aux_ctrl
// Purpose: groups the per-channel configuration, interrupt clear and status
//          lines exchanged between the GPIO register bank and gpio_aux_ctrl.
// Signals:
//   cfg_dir      1 = output (per channel)
//   cfg_mode     0 = static cfg_out, 1 = PWM (per channel)
//   cfg_out      static output value (per channel)
//   cfg_duty     per-channel duty, channel i at [i*PWM_W +: PWM_W]
//   cfg_prescale PWM tick every cfg_prescale+1 clocks
//   cfg_debounce shared debounce threshold
//   cfg_rise_en  enable rising-edge flagging (per channel)
//   cfg_fall_en  enable falling-edge flagging (per channel)
//   irq_clr      single-cycle write-one-to-clear of pending bits
//   in_state     debounced input state (per channel)
//   irq_pending  sticky edge flags (per channel)
//   irq          OR of irq_pending
// Modports: master = register bank, slave = gpio_aux_ctrl.
interface gpio_aux_ctrl_if #(
  parameter int NUM_CH     = 13,
  parameter int DEBOUNCE_W = 16,
  parameter int PWM_W      = 8,
  parameter int PRESCALE_W = 8
);
  logic [NUM_CH-1:0]       cfg_dir;
  logic [NUM_CH-1:0]       cfg_mode;
  logic [NUM_CH-1:0]       cfg_out;
  logic [NUM_CH*PWM_W-1:0] cfg_duty;
  logic [PRESCALE_W-1:0]   cfg_prescale;
  logic [DEBOUNCE_W-1:0]   cfg_debounce;
  logic [NUM_CH-1:0]       cfg_rise_en;
  logic [NUM_CH-1:0]       cfg_fall_en;
  logic [NUM_CH-1:0]       irq_clr;
  logic [NUM_CH-1:0]       in_state;
  logic [NUM_CH-1:0]       irq_pending;
  logic                    irq;

  modport master (
    output cfg_dir, cfg_mode, cfg_out, cfg_duty, cfg_prescale, cfg_debounce,
    output cfg_rise_en, cfg_fall_en, irq_clr,
    input  in_state, irq_pending, irq
  );

  modport slave (
    input  cfg_dir, cfg_mode, cfg_out, cfg_duty, cfg_prescale, cfg_debounce,
    input  cfg_rise_en, cfg_fall_en, irq_clr,
    output in_state, irq_pending, irq
  );
endinterface

// File: rtl/gpio_aux_ctrl.sv
// rtl/gpio_aux_ctrl.sv - N-channel auxiliary GPIO front-end (sync, debounce, edge irq, PWM out)
// Purpose: sits between the GPIO register bank and the pad buffers. Each
//          channel has a 2-FF synchroniser, a debouncer, sticky rise/fall
//          interrupt flags and a static or PWM-driven registered output.
// Ports:
//   clk         single clock for all logic
//   resetn      asynchronous active-low reset
//   gpio_pin_i  pad readback
//   gpio_pin_o  pad drive value
//   gpio_pin_t  pad tristate, 1 = high-Z
//   bus         gpio_aux_ctrl_if.slave: configuration in, status/irq out
module gpio_aux_ctrl #(
  parameter int NUM_CH     = 13,
  parameter int DEBOUNCE_W = 16,
  parameter int PWM_W      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] gpio_pin_i,
  output logic [NUM_CH-1:0] gpio_pin_o,
  output logic [NUM_CH-1:0] gpio_pin_t,
  gpio_aux_ctrl_if.slave    bus
);

  logic [NUM_CH-1:0]     r_sync1;
  logic [NUM_CH-1:0]     r_sync2;
  logic [DEBOUNCE_W-1:0] r_db_cnt [NUM_CH];
  logic [NUM_CH-1:0]     r_in_state;
  logic [NUM_CH-1:0]     r_in_prev;
  logic [NUM_CH-1:0]     r_irq_pending;
  logic [PRESCALE_W-1:0] r_ps;
  logic [PWM_W-1:0]      r_pc;
  logic [PWM_W-1:0]      r_duty_sh [NUM_CH];

  logic                  w_tick;
  logic                  w_wrap;
  logic [NUM_CH-1:0]     w_rise;
  logic [NUM_CH-1:0]     w_fall;
  logic [NUM_CH-1:0]     w_pwm;

  // Synchroniser and debouncer. A channel's counter only runs while the
  // synchronised pin disagrees with the accepted state, so any agreeing
  // sample restarts the qualification window.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_in_state <= '0;
      r_in_prev  <= '0;
      for (int i = 0; i < NUM_CH; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= gpio_pin_i;
      r_sync2   <= r_sync1;
      r_in_prev <= r_in_state;
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_sync2[i] == r_in_state[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == bus.cfg_debounce) begin
          r_in_state[i] <= r_sync2[i];
          r_db_cnt[i]   <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  // Edges are taken from the registered state history, so flags appear one
  // clock after in_state moves. A new edge outranks a same-cycle clear.
  assign w_rise = r_in_state & ~r_in_prev & bus.cfg_rise_en;
  assign w_fall = ~r_in_state & r_in_prev & bus.cfg_fall_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq_pending <= '0;
    end else begin
      r_irq_pending <= (r_irq_pending & ~bus.irq_clr) | w_rise | w_fall;
    end
  end

  assign bus.in_state    = r_in_state;
  assign bus.irq_pending = r_irq_pending;
  assign bus.irq         = |r_irq_pending;

  // PWM timebase. Duty is shadowed only on the tick that wraps the period
  // counter, so a mid-period write never shortens or stretches a pulse.
  assign w_tick = (r_ps == bus.cfg_prescale);
  assign w_wrap = w_tick && (r_pc == '1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ps <= '0;
      r_pc <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= '0;
    end else begin
      r_ps <= w_tick ? '0 : r_ps + PRESCALE_W'(1);
      if (w_tick) r_pc <= r_pc + PWM_W'(1);
      if (w_wrap) begin
        for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= bus.cfg_duty[i*PWM_W +: PWM_W];
      end
    end
  end

  always_comb begin
    w_pwm = '0;
    for (int i = 0; i < NUM_CH; i++) w_pwm[i] = (r_pc < r_duty_sh[i]);
  end

  // Registered pad controls keep the pads free of combinational glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio_pin_t <= '1;
      gpio_pin_o <= '0;
    end else begin
      gpio_pin_t <= ~bus.cfg_dir;
      gpio_pin_o <= (bus.cfg_mode & w_pwm) | (~bus.cfg_mode & bus.cfg_out);
    end
  end

endmodule

// File: doc/gpio_aux_ctrl.md
# gpio_aux_ctrl

Parametrised GPIO front-end for the board-level auxiliary pins: LEDs, switches, LCD control lines and similar. It sits between the PS/AXI GPIO register bank and the `ad_iobuf` pad buffers. Per channel it provides a 2-FF input synchroniser, a programmable debouncer, rise/fall edge interrupts with sticky pending bits, and either a static or a PWM-driven output with glitch-free duty update. It generalises the fixed 13-bit pass-through GPIO wiring to N channels with per-channel mode.

## Interface

Parameters:
- `NUM_CH`, 13, number of GPIO channels.
- `DEBOUNCE_W`, 16, debounce counter and threshold width.
- `PWM_W`, 8, PWM counter and duty width; PWM period is 2^PWM_W ticks.
- `PRESCALE_W`, 8, PWM prescaler width.

Ports:
- `clk`, in, 1, single clock for all logic.
- `resetn`, in, 1, asynchronous active-low reset.
- `gpio_pin_i`, in, NUM_CH, pad readback (to `ad_iobuf` dio_o).
- `gpio_pin_o`, out, NUM_CH, pad drive value (to dio_i).
- `gpio_pin_t`, out, NUM_CH, pad tristate (to dio_t); 1 = high-Z.
- `cfg_dir`, in, NUM_CH, 1 = output.
- `cfg_mode`, in, NUM_CH, 0 = static `cfg_out`, 1 = PWM.
- `cfg_out`, in, NUM_CH, static output value.
- `cfg_duty`, in, NUM_CH*PWM_W, per-channel duty; channel i at bits [i*PWM_W +: PWM_W].
- `cfg_prescale`, in, PRESCALE_W, PWM tick every cfg_prescale+1 clocks.
- `cfg_debounce`, in, DEBOUNCE_W, shared debounce threshold D.
- `cfg_rise_en`, in, NUM_CH, enable rising-edge flagging per channel.
- `cfg_fall_en`, in, NUM_CH, enable falling-edge flagging per channel.
- `irq_clr`, in, NUM_CH, single-cycle write-one-to-clear of pending bits.
- `in_state`, out, NUM_CH, debounced input state.
- `irq_pending`, out, NUM_CH, sticky edge flags.
- `irq`, out, 1, OR of `irq_pending`.

## Operation

- Sync: 2-FF chain on each `gpio_pin_i` bit. Both stages reset to 0.
- Debounce, per channel, counter `cnt[DEBOUNCE_W]`:
  - sync == in_state: cnt <= 0.
  - otherwise, if cnt == D: in_state <= sync and cnt <= 0; else cnt <= cnt+1.
  - D = 0 means one-cycle acceptance.
  - A mismatch shorter than D+1 cycles leaves in_state unchanged and resets cnt.
  - D is sampled live; lowering D below a running cnt delays acceptance until cnt wraps. Software changes D only while inputs are idle.
- Inputs are monitored regardless of `cfg_dir`; output channels debounce their own readback.
- Edge flags: an in_state 0→1 update sets pending[i] if rise_en[i]; a 1→0 update sets it if fall_en[i].
  - Pending bits are sticky.
  - irq_clr[i] clears pending[i] on the next edge.
  - Set and clear in the same cycle: set wins.
- `irq` = |irq_pending, driven from registers with no added latency.
- Prescaler: counter `ps` counts 0..cfg_prescale; tick when ps == cfg_prescale.
- PWM counter `pc[PWM_W]` increments on each tick and wraps from 2^PWM_W−1 to 0.
- Duty shadow: each channel's cfg_duty is copied to `duty_sh[i]` on the tick where pc wraps to 0. Changes made mid-period never glitch the current period.
- pwm[i] = (pc < duty_sh[i]).
  - duty 0 → constant 0.
  - duty 2^PWM_W−1 → high for all but 1 tick per period.
- Output registers:
  - gpio_pin_t <= ~cfg_dir.
  - gpio_pin_o <= cfg_mode[i] ? pwm[i] : cfg_out[i].
- Reset values:
  - gpio_pin_t all 1; gpio_pin_o 0.
  - in_state 0; irq_pending 0; irq 0.
  - ps, pc, duty_sh, debounce counters 0.
- Asynchronous reset mid-operation returns every register to its reset value immediately. The first PWM period after release starts at pc = 0 with duty_sh = 0, so all PWM outputs are low for the first full period.

## Timing

- Pad change → in_state change: D+3 clocks (2 sync + D+1 debounce).
- in_state change → irq_pending/irq: 1 clock.
- irq_clr → pending clear: 1 clock.
- cfg_dir/cfg_out/cfg_mode → pins: 1 clock.
- PWM period: (cfg_prescale+1)·2^PWM_W clocks.
- Duty update takes effect at the first period boundary after the write.

## Test plan

- Reset: hold resetn=0 → gpio_pin_t=13'h1FFF, gpio_pin_o=0, in_state=0, irq=0. Assert reset mid-PWM → outputs return to these values in the same cycle.
- Debounce, D=4:
  - Pin 3 steps 0→1 and is held → in_state[3]=1 exactly 7 clocks later.
  - 4-clock high glitch → in_state and irq unchanged.
- IRQ, rise_en[2]=1, fall_en[2]=0:
  - Pin 2 rises → pending[2]=1 and irq=1 at D+4 clocks.
  - Pin falls → no new flag.
  - irq_clr[2] pulse → pending clears next clock.
  - irq_clr coincident with a new accepted rise → pending stays 1.
- PWM, PWM_W=8, prescale=0, ch0 dir=1 mode=1 duty=64 → 64 high / 192 low per 256 clocks. duty=0 → constant 0. duty=255 → 255 high / 1 low.
- Duty change 64→128 written at pc=100 → current period stays 64 high; next period is 128 high. prescale=3 → period 1024 clocks.
- Static mode, dir=0 → pin_t=1; dir=1, out=1 → pin_t=0, pin_o=1 one clock after the config change.
